// File: rtl/fc_ibuf_loader_if.sv
// fc_ibuf_loader_if
//   Bundle of the loader's producer-side strobe, input-buffer write port and
//   consumer start handshake.
//   Producer side : i_valid, i_data (to loader), o_busy (from loader)
//   Buffer side   : o_ibuf_we, o_ibuf_addr, o_ibuf_wr_data (from loader)
//   Consumer side : i_next_busy (to loader), o_next_start (from loader)
//   Modports: slave = the loader, master = whatever drives/observes it.
interface fc_ibuf_loader_if #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_busy;
  logic                  o_ibuf_we;
  logic [ADDR_WIDTH-1:0] o_ibuf_addr;
  logic [DATA_WIDTH-1:0] o_ibuf_wr_data;
  logic                  i_next_busy;
  logic                  o_next_start;

  modport slave (
    input  i_valid, i_data, i_next_busy,
    output o_busy, o_ibuf_we, o_ibuf_addr, o_ibuf_wr_data, o_next_start
  );

  modport master (
    output i_valid, i_data, i_next_busy,
    input  o_busy, o_ibuf_we, o_ibuf_addr, o_ibuf_wr_data, o_next_start
  );
endinterface

// File: rtl/fc_ibuf_loader.sv
// fc_ibuf_loader
//   Writes single-cycle activation strobes into input-buffer addresses
//   0..num_inputs-1, then starts the consuming layer once a full vector is
//   stored. Strobes are refused (o_busy) while the consumer may be reading.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     bus       : fc_ibuf_loader_if.slave (strobe in, buffer write out,
//                 consumer busy in / start out)
//     o_err     : sticky dropped-strobe flag, only when FC_IBUF_LOADER_ERR_EN
//                 is defined
//   Parameters: num_inputs (>= 2), DATA_WIDTH. The interface ADDR_WIDTH must
//   equal $clog2(num_inputs).
module fc_ibuf_loader #(
  parameter int unsigned num_inputs = 4096,
  parameter int unsigned DATA_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fc_ibuf_loader_if.slave      bus
`ifdef FC_IBUF_LOADER_ERR_EN
  ,
  output logic                 o_err
`endif
);

  localparam int unsigned AW = $clog2(num_inputs);
  localparam logic [AW-1:0] LAST_ADDR = AW'(num_inputs - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AW-1:0]         r_wcnt;
  logic [AW-1:0]         w_wcnt_nxt;
  logic                  w_accept;
  logic                  w_busy;
  logic                  w_start;
  logic                  r_ibuf_we;
  logic [AW-1:0]         r_ibuf_addr;
  logic [DATA_WIDTH-1:0] r_ibuf_wr_data;

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_busy      = 1'b1;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      FILL: begin
        w_busy   = bus.i_next_busy;
        w_accept = bus.i_valid & ~bus.i_next_busy;
        if (w_accept) begin
          // Explicit wrap keeps the counter inside 0..num_inputs-1 for
          // non-power-of-two vector lengths.
          if (r_wcnt == LAST_ADDR) begin
            w_wcnt_nxt  = '0;
            w_state_nxt = LAUNCH;
          end else begin
            w_wcnt_nxt = r_wcnt + AW'(1);
          end
        end
      end
      LAUNCH: begin
        // The final element is still being written on the first LAUNCH
        // cycle; holding the start off while r_ibuf_we is high guarantees
        // the consumer never sees the pulse alongside the last write.
        if (!bus.i_next_busy && !r_ibuf_we) begin
          w_start     = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Consumer raises busy one cycle after start; wait for it so the
        // buffer is not refilled before reading has begun.
        if (bus.i_next_busy) begin
          w_state_nxt = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ibuf_we      <= 1'b0;
      r_ibuf_addr    <= '0;
      r_ibuf_wr_data <= '0;
    end else begin
      r_ibuf_we <= w_accept;
      if (w_accept) begin
        r_ibuf_addr    <= r_wcnt;
        r_ibuf_wr_data <= bus.i_data;
      end
    end
  end

  assign bus.o_busy         = w_busy;
  assign bus.o_next_start   = w_start;
  assign bus.o_ibuf_we      = r_ibuf_we;
  assign bus.o_ibuf_addr    = r_ibuf_addr;
  assign bus.o_ibuf_wr_data = r_ibuf_wr_data;

`ifdef FC_IBUF_LOADER_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (bus.i_valid && w_busy) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`endif

endmodule

// File: tb/tb_fc_ibuf_loader.sv
module tb_fc_ibuf_loader;

  localparam int unsigned DW  = 2;
  localparam int unsigned NA  = 4;
  localparam int unsigned NB  = 5;
  localparam int unsigned AWA = $clog2(NA);
  localparam int unsigned AWB = $clog2(NB);

  logic clk;
  logic rst;

  fc_ibuf_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWA)) bus_a ();
  fc_ibuf_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWB)) bus_b ();

`ifdef FC_IBUF_LOADER_ERR_EN
  logic err_a;
  logic err_b;
`endif

  fc_ibuf_loader #(.num_inputs(NA), .DATA_WIDTH(DW)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
`ifdef FC_IBUF_LOADER_ERR_EN
    ,
    .o_err (err_a)
`endif
  );

  fc_ibuf_loader #(.num_inputs(NB), .DATA_WIDTH(DW)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
`ifdef FC_IBUF_LOADER_ERR_EN
    ,
    .o_err (err_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       nb;
    logic       busy;
    logic       st;
    logic       we;
    logic       err;
    logic       vb;
    logic [1:0] db;
    logic       nbb;
    logic       stb;
  } row_t;

  typedef struct {
    logic [2:0] addr;
    logic [1:0] data;
  } wr_t;

  row_t tbl [22];
  wr_t  qa [$];
  wr_t  qb [$];
  int   n_pass;
  int   n_total;
  int   mcnt_a;
  int   mcnt_b;

  function automatic row_t mk(input int v, input int d, input int nb,
                              input int busy, input int st, input int we,
                              input int err, input int vb, input int db,
                              input int nbb, input int stb);
    row_t r;
    r.v = v[0];  r.d = d[1:0];  r.nb = nb[0];
    r.busy = busy[0];  r.st = st[0];  r.we = we[0];  r.err = err[0];
    r.vb = vb[0];  r.db = db[1:0];  r.nbb = nbb[0];  r.stb = stb[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Expected write for an accepted strobe; address follows the bench's own
  // modulo counter.
  task automatic push_a(input logic [1:0] d);
    wr_t w;
    w.addr = 3'(mcnt_a);
    w.data = d;
    qa.push_back(w);
    mcnt_a = (mcnt_a == int'(NA) - 1) ? 0 : mcnt_a + 1;
  endtask

  task automatic push_b(input logic [1:0] d);
    wr_t w;
    w.addr = 3'(mcnt_b);
    w.data = d;
    qb.push_back(w);
    mcnt_b = (mcnt_b == int'(NB) - 1) ? 0 : mcnt_b + 1;
  endtask

  task automatic monitor(input string tag);
    wr_t w;
    if (bus_a.o_ibuf_we === 1'b1) begin
      if (qa.size() == 0) begin
        chk({tag, "_a_unexpected_we"}, 32'd1, 32'd0);
      end else begin
        w = qa.pop_front();
        chk({tag, "_a_addr"}, 32'(bus_a.o_ibuf_addr), 32'(w.addr));
        chk({tag, "_a_data"}, 32'(bus_a.o_ibuf_wr_data), 32'(w.data));
      end
    end
    if (bus_b.o_ibuf_we === 1'b1) begin
      if (qb.size() == 0) begin
        chk({tag, "_b_unexpected_we"}, 32'd1, 32'd0);
      end else begin
        w = qb.pop_front();
        chk({tag, "_b_addr"}, 32'(bus_b.o_ibuf_addr), 32'(w.addr));
        chk({tag, "_b_data"}, 32'(bus_b.o_ibuf_wr_data), 32'(w.data));
      end
    end
  endtask

  task automatic drive_a(input logic v, input logic [1:0] d, input logic nb);
    bus_a.i_valid     = v;
    bus_a.i_data      = d;
    bus_a.i_next_busy = nb;
  endtask

  task automatic drive_b(input logic v, input logic [1:0] d, input logic nb);
    bus_b.i_valid     = v;
    bus_b.i_data      = d;
    bus_b.i_next_busy = nb;
  endtask

  initial begin
    int starts;
    logic [1:0] pat [4];
    n_pass = 0;
    n_total = 0;
    mcnt_a = 0;
    mcnt_b = 0;
    pat[0] = 2'd3; pat[1] = 2'd2; pat[2] = 2'd1; pat[3] = 2'd0;

    //            v d nb busy st we err  vb db nbb stb
    tbl[0]  = mk(1,1,0, 0,0,0,0, 1,1,0,0);
    tbl[1]  = mk(1,2,0, 0,0,1,0, 1,2,0,0);
    tbl[2]  = mk(1,3,0, 0,0,1,0, 1,3,0,0);
    tbl[3]  = mk(1,0,0, 0,0,1,0, 1,0,0,0);
    tbl[4]  = mk(0,0,0, 1,0,1,0, 1,1,0,0);
    tbl[5]  = mk(0,0,0, 1,1,0,0, 0,0,0,0);
    tbl[6]  = mk(1,2,0, 1,0,0,0, 0,0,0,1);
    tbl[7]  = mk(0,0,1, 1,0,0,1, 0,0,1,0);
    tbl[8]  = mk(0,0,1, 1,0,0,1, 1,2,0,0);
    tbl[9]  = mk(1,3,1, 1,0,0,1, 1,3,0,0);
    tbl[10] = mk(0,0,0, 0,0,0,1, 1,0,0,0);
    tbl[11] = mk(1,0,0, 0,0,0,1, 1,1,0,0);
    tbl[12] = mk(1,1,0, 0,0,1,1, 1,2,0,0);
    tbl[13] = mk(1,2,0, 0,0,1,1, 0,0,0,0);
    tbl[14] = mk(1,3,0, 0,0,1,1, 0,0,0,1);
    tbl[15] = mk(0,0,1, 1,0,1,1, 0,0,0,0);
    tbl[16] = mk(0,0,1, 1,0,0,1, 0,0,0,0);
    tbl[17] = mk(0,0,0, 1,1,0,1, 0,0,0,0);
    tbl[18] = mk(0,0,1, 1,0,0,1, 0,0,0,0);
    tbl[19] = mk(0,0,1, 1,0,0,1, 0,0,0,0);
    tbl[20] = mk(1,1,0, 0,0,0,1, 0,0,0,0);
    tbl[21] = mk(0,0,0, 0,0,1,1, 0,0,0,0);

    // Reset values; o_busy follows i_next_busy because reset lands in FILL.
    rst = 1'b1;
    drive_a(1'b0, 2'd0, 1'b1);
    drive_b(1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("rst_we",    32'(bus_a.o_ibuf_we), 32'd0);
    chk("rst_addr",  32'(bus_a.o_ibuf_addr), 32'd0);
    chk("rst_data",  32'(bus_a.o_ibuf_wr_data), 32'd0);
    chk("rst_start", 32'(bus_a.o_next_start), 32'd0);
    chk("rst_busy_hi", 32'(bus_a.o_busy), 32'd1);
`ifdef FC_IBUF_LOADER_ERR_EN
    chk("rst_err", 32'(err_a), 32'd0);
`endif
    drive_a(1'b0, 2'd0, 1'b0);
    #1;
    chk("rst_busy_lo", 32'(bus_a.o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cycle-accurate table: full frame, dropped strobes, held-off start,
    // and the num_inputs=5 instance running two frames alongside.
    for (int unsigned i = 0; i < 22; i++) begin
      @(posedge clk);
      #1;
      drive_a(tbl[i].v, tbl[i].d, tbl[i].nb);
      drive_b(tbl[i].vb, tbl[i].db, tbl[i].nbb);
      if (tbl[i].v && !tbl[i].busy) push_a(tbl[i].d);
      if (tbl[i].vb) push_b(tbl[i].db);
      @(negedge clk);
      chk($sformatf("c%0d_busy", i),  32'(bus_a.o_busy), 32'(tbl[i].busy));
      chk($sformatf("c%0d_start", i), 32'(bus_a.o_next_start), 32'(tbl[i].st));
      chk($sformatf("c%0d_we", i),    32'(bus_a.o_ibuf_we), 32'(tbl[i].we));
      chk($sformatf("c%0d_startb", i), 32'(bus_b.o_next_start), 32'(tbl[i].stb));
`ifdef FC_IBUF_LOADER_ERR_EN
      chk($sformatf("c%0d_err", i), 32'(err_a), 32'(tbl[i].err));
`endif
      monitor($sformatf("c%0d", i));
    end

    // Reset mid-frame: two accepts (wcnt 1 -> 2), then async reset while a
    // write is on the outputs.
    @(posedge clk);
    #1;
    drive_a(1'b1, 2'd2, 1'b0);
    drive_b(1'b0, 2'd0, 1'b0);
    push_a(2'd2);
    @(negedge clk);
    monitor("mid");
    @(posedge clk);
    #1;
    drive_a(1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_we",    32'(bus_a.o_ibuf_we), 32'd0);
    chk("arst_addr",  32'(bus_a.o_ibuf_addr), 32'd0);
    chk("arst_data",  32'(bus_a.o_ibuf_wr_data), 32'd0);
    chk("arst_start", 32'(bus_a.o_next_start), 32'd0);
`ifdef FC_IBUF_LOADER_ERR_EN
    chk("arst_err", 32'(err_a), 32'd0);
`endif
    qa.delete();
    qb.delete();
    mcnt_a = 0;
    mcnt_b = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      drive_a(1'b1, pat[k], 1'b0);
      push_a(pat[k]);
      @(negedge clk);
      chk($sformatf("refill%0d_busy", k), 32'(bus_a.o_busy), 32'd0);
      monitor($sformatf("refill%0d", k));
    end
    starts = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      drive_a(1'b0, 2'd0, 1'b0);
      @(negedge clk);
      if (bus_a.o_next_start === 1'b1) starts++;
      monitor($sformatf("post%0d", k));
    end
    chk("reset_start_cnt", 32'(starts), 32'd1);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
